// File: rtl/register_file.sv
// Multi-ported register file: one write port, two combinational read ports,
// plus a sequential clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic              wr_en;
    logic              clr_en;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_en    = 1'b0;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_busy  = 1'b1;
                clr_en    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes are blocked only while the clear engine owns the array.
    assign wr_en = we && (32'(waddr) < DEPTH) && (state_q != CLEAR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: the array itself is reset here because reset must zero contents immediately; this rules out a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_en) begin
            regs_q[clr_cnt_q[IDX_W-1:0]] <= '0;
        end else if (wr_en) begin
            regs_q[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (32'(raddr_a) < DEPTH) begin
            rdata_a = regs_q[raddr_a[IDX_W-1:0]];
        end
        if (32'(raddr_b) < DEPTH) begin
            rdata_b = regs_q[raddr_b[IDX_W-1:0]];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if (wr_en && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (WIDTH=16, DEPTH=8, ADDR_W=4).
module tb_register_file;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [WIDTH-1:0]  wdata = '0;
    logic [ADDR_W-1:0] raddr_a = '0;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b = '0;
    logic [WIDTH-1:0]  rdata_b;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic              clr_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] model [DEPTH];

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
        if (a < 4'd8) model[a[2:0]] = d;
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) begin
            write_word(4'(i), 16'h1000 + 16'(i) * 16'h0101);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #11;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", clr_done); end
        raddr_a = 4'd0; raddr_b = 4'd7; #1;
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL reset_rd0: got %h expected 0000", rdata_a); end
        n_cmp++; if (rdata_b !== 16'h0000) begin n_err++; $display("FAIL reset_rd7: got %h expected 0000", rdata_b); end
    endtask

    task automatic test_write_read();
        // Release reset with a write already presented: the first edge must take it.
        @(negedge clk);
        we = 1'b1; waddr = 4'd2; wdata = 16'hAAAA; rst_n = 1'b1;
        step();
        model[2] = 16'hAAAA;
        waddr = 4'd3; wdata = 16'h5555; raddr_a = 4'd2; #1;
        n_cmp++; if (rdata_a !== 16'hAAAA) begin n_err++; $display("FAIL first_write: got %h expected aaaa", rdata_a); end
        step();
        we = 1'b0;
        model[3] = 16'h5555;
        raddr_a = 4'd2; raddr_b = 4'd3; #1;
        n_cmp++; if (rdata_a !== 16'hAAAA) begin n_err++; $display("FAIL wr_rd_a: got %h expected aaaa", rdata_a); end
        n_cmp++; if (rdata_b !== 16'h5555) begin n_err++; $display("FAIL wr_rd_b: got %h expected 5555", rdata_b); end
    endtask

    task automatic test_hold();
        we = 1'b0; waddr = 4'd2; wdata = 16'hFFFF;
        step();
        step();
        raddr_a = 4'd2; #1;
        n_cmp++; if (rdata_a !== 16'hAAAA) begin n_err++; $display("FAIL hold: got %h expected aaaa", rdata_a); end
        write_word(4'd2, 16'hFFFF);
        #1;
        n_cmp++; if (rdata_a !== 16'hFFFF) begin n_err++; $display("FAIL rewrite: got %h expected ffff", rdata_a); end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_v;
`ifdef REGFILE_BYPASS_EN
        exp_v = 16'h1234;
`else
        exp_v = 16'h0000;
`endif
        raddr_a = 4'd5; raddr_b = 4'd5;
        we = 1'b1; waddr = 4'd5; wdata = 16'h1234; #1;
        n_cmp++; if (rdata_a !== exp_v) begin n_err++; $display("FAIL same_cycle_a: got %h expected %h", rdata_a, exp_v); end
        n_cmp++; if (rdata_b !== exp_v) begin n_err++; $display("FAIL same_cycle_b: got %h expected %h", rdata_b, exp_v); end
        step();
        we = 1'b0;
        model[5] = 16'h1234;
        #1;
        n_cmp++; if (rdata_a !== 16'h1234) begin n_err++; $display("FAIL after_edge_a: got %h expected 1234", rdata_a); end
        n_cmp++; if (rdata_b !== 16'h1234) begin n_err++; $display("FAIL after_edge_b: got %h expected 1234", rdata_b); end
    endtask

    task automatic test_out_of_range();
        raddr_a = 4'd9;
        we = 1'b1; waddr = 4'd9; wdata = 16'hBEEF; #1;
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL oor_read_during_wr: got %h expected 0000", rdata_a); end
        step();
        we = 1'b0; #1;
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL oor_read: got %h expected 0000", rdata_a); end
        for (int i = 0; i < DEPTH; i++) begin
            raddr_b = 4'(i); #1;
            n_cmp++; if (rdata_b !== model[i]) begin n_err++; $display("FAIL oor_no_change[%0d]: got %h expected %h", i, rdata_b, model[i]); end
        end
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] orig [DEPTH];
        fill_all();
        // Write and clear request together: the write lands, then the sweep erases it.
        we = 1'b1; waddr = 4'd4; wdata = 16'h4444; clr_req = 1'b1;
        step();
        we = 1'b0; clr_req = 1'b0;
        model[4] = 16'h4444;
        for (int i = 0; i < DEPTH; i++) orig[i] = model[i];
        raddr_a = 4'd4; #1;
        n_cmp++; if (rdata_a !== 16'h4444) begin n_err++; $display("FAIL wr_with_clr: got %h expected 4444", rdata_a); end
        for (int k = 0; k < DEPTH; k++) begin
            raddr_a = 4'(k);
            raddr_b = (k == 0) ? 4'd0 : 4'(k - 1);
            #1;
            n_cmp++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL clr_busy[%0d]: got %b expected 1", k, clr_busy); end
            n_cmp++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL clr_done_early[%0d]: got %b expected 0", k, clr_done); end
            n_cmp++; if (rdata_a !== orig[k]) begin n_err++; $display("FAIL partial_keep[%0d]: got %h expected %h", k, rdata_a, orig[k]); end
            if (k > 0) begin
                n_cmp++; if (rdata_b !== 16'h0000) begin n_err++; $display("FAIL partial_zero[%0d]: got %h expected 0000", k, rdata_b); end
            end
            if (k == 3) begin we = 1'b1; waddr = 4'd0; wdata = 16'hDEAD; end
            if (k == 5) clr_req = 1'b1;
            step();
            we = 1'b0; clr_req = 1'b0;
        end
        #1;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b expected 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %b expected 1", clr_done); end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0; #1;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b expected 0", clr_done); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = 4'(i); #1;
            n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL cleared[%0d]: got %h expected 0000", i, rdata_a); end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(); step(); step();
        raddr_a = 4'd6; raddr_b = 4'd5;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", clr_done); end
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL abort_rd6: got %h expected 0000", rdata_a); end
        n_cmp++; if (rdata_b !== 16'h0000) begin n_err++; $display("FAIL abort_rd5: got %h expected 0000", rdata_b); end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++; if ((clr_done !== 1'b0) || (clr_busy !== 1'b0)) begin n_err++; $display("FAIL post_abort[%0d]: got busy=%b done=%b expected 0/0", c, clr_busy, clr_done); end
        end
        write_word(4'd1, 16'h0F0F);
        raddr_a = 4'd1; #1;
        n_cmp++; if (rdata_a !== 16'h0F0F) begin n_err++; $display("FAIL post_abort_write: got %h expected 0f0f", rdata_a); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_bypass();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width of each register in bits.
REQ-002 SHALL provide parameter DEPTH, default 8, number of registers (2..256).
REQ-003 SHALL provide parameter ADDR_W, default 3, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port we  input  1  write enable.
REQ-007 SHALL provide port waddr  input  ADDR_W  write address.
REQ-008 SHALL provide port wdata  input  WIDTH  write data.
REQ-009 SHALL provide port raddr_a  input  ADDR_W  read port A address.
REQ-010 SHALL provide port rdata_a  output  WIDTH  read port A data.
REQ-011 SHALL provide port raddr_b  input  ADDR_W  read port B address.
REQ-012 SHALL provide port rdata_b  output  WIDTH  read port B data.
REQ-013 SHALL provide port clr_req  input  1  request to zero all registers.
REQ-014 SHALL provide port clr_busy  output  1  high while clear sequence runs.
REQ-015 SHALL provide port clr_done  output  1  one-cycle pulse at clear completion.

Function
REQ-016 SHALL write wdata into reg[waddr] on rising clk when we=1, waddr<DEPTH and FSM in IDLE or DONE.
REQ-017 SHALL hold all register contents when we=0 (no write, no change).
REQ-018 SHALL ignore writes with waddr>=DEPTH; reads with raddr>=DEPTH SHALL return 0.
REQ-019 SHALL drive rdata_a/rdata_b combinationally from reg[raddr_a]/reg[raddr_b], zero-cycle latency; both ports independent, same address allowed.
REQ-020 SHALL implement clear FSM with states IDLE, CLEAR, DONE and a counter clr_cnt of width ADDR_W.
REQ-021 IDLE -> CLEAR on rising clk with clr_req=1; clr_cnt loaded to 0.
REQ-022 In CLEAR, each cycle SHALL set reg[clr_cnt] to 0 and increment clr_cnt; at clr_cnt=DEPTH-1 transition to DONE after clearing that entry.
REQ-023 DONE -> IDLE unconditionally after one cycle; clr_done=1 only in DONE.
REQ-024 clr_busy SHALL be 1 exactly in CLEAR; clear occupies DEPTH cycles, clr_done follows in cycle DEPTH+1.
REQ-025 Writes SHALL be ignored in CLEAR; clr_req SHALL be ignored in CLEAR and DONE.
REQ-026 Simultaneous we and clr_req in IDLE: write SHALL complete that edge; clear then overwrites it.
REQ-027 Reads in CLEAR SHALL return current, partially cleared contents.

Reset
REQ-028 rst_n=0 SHALL immediately, without clk, zero all registers, clr_cnt=0, FSM=IDLE, clr_busy=0, clr_done=0.
REQ-029 Reset asserted mid-clear SHALL abort the sequence; no clr_done pulse after release.
REQ-030 First write SHALL occur on the first rising clk after rst_n deasserts.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: when we=1, write accepted per REQ-016 and raddr_x=waddr, rdata_x SHALL equal wdata in the same cycle.
REQ-032 REGFILE_BYPASS_EN undefined: rdata_x SHALL show the old value until after the write edge.

Verification
REQ-033 Reset, we=1 waddr=2 wdata=16'hAAAA, next cycle waddr=3 wdata=16'h5555 -> raddr_a=2 gives AAAA, raddr_b=3 gives 5555.
REQ-034 we=0 with wdata=16'hFFFF waddr=2 for 2 cycles -> reg[2] stays AAAA; we=1 again -> FFFF after the edge.
REQ-035 Fill all 8 regs, pulse clr_req -> clr_busy high 8 cycles, clr_done one pulse on cycle 9, all reads 0; write during busy ignored.
REQ-036 Assert rst_n=0 mid-clear (cycle 4) between clock edges -> outputs 0 immediately, clr_busy=0, no clr_done.
REQ-037 we=1 waddr=5 wdata=16'h1234, raddr_a=5 same cycle -> 16'h1234 with REGFILE_BYPASS_EN, old value (0) without.
REQ-038 raddr_a=9 with DEPTH=8, ADDR_W=4, and write to waddr=9 -> rdata_a=0, no register changes.
